step_pulse_arbiter: RTL and testbench

STEP_PULSE_ARBITER -- requirements
Module: step_pulse_arbiter

---
 rtl/step_pulse_arbiter.sv | 129 ++++++++++++
 tb/tb_step_pulse_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_arbiter.sv
// Two-key up/down stepper: synchronizes and debounces the keys, arbitrates
// between them and emits one-cycle step pulses with auto-repeat and bound blocking.
module step_pulse_arbiter #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter int         REPEAT_CYCLES   = 8,
   parameter logic [3:0] CNT_MAX         = 4'd15
) (
   input  logic       FPGA_CLK,
   input  logic       FPGA_RST_N,
   input  logic       key_up,
   input  logic       key_down,
   input  logic [3:0] count_value,
   output logic       flag_light_1,
   output logic       flag_light_2,
   output logic       blocked,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      FIRE,
      HOLD,
      RELEASE
   } state_t;

   localparam int TW = 20;
   localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);
   localparam logic [TW-1:0] T_MAX    = '1;

   state_t        state;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_inc;
   logic [1:0]    up_sync;
   logic [1:0]    down_sync;
   logic          up_s;
   logic          down_s;
   logic          dir_up;
   logic          rr_up;
   logic          key_s;
   logic          grant_up;
   logic          step_up;
   logic          step_dn;
   logic          step_blk;

   assign up_s      = up_sync[1];
   assign down_s    = down_sync[1];
   assign key_s     = dir_up ? up_s : down_s;
   assign grant_up  = (up_s && down_s) ? rr_up : up_s;
   assign timer_inc = (timer == T_MAX) ? timer : timer + 1'b1;
   assign busy      = (state != IDLE);

   // Bound check uses the value present on the cycle the step is committed
   assign step_up  = dir_up && (count_value != CNT_MAX);
   assign step_dn  = !dir_up && (count_value != 4'd0);
   assign step_blk = dir_up ? (count_value == CNT_MAX)
                            : (count_value == 4'd0);

   always_ff @(posedge FPGA_CLK) begin
      if (!FPGA_RST_N) begin
         state        <= IDLE;
         timer        <= '0;
         up_sync      <= '0;
         down_sync    <= '0;
         dir_up       <= 1'b1;
         rr_up        <= 1'b1;
         flag_light_1 <= 1'b0;
         flag_light_2 <= 1'b0;
         blocked      <= 1'b0;
      end else begin
         up_sync      <= {up_sync[0], key_up};
         down_sync    <= {down_sync[0], key_down};
         flag_light_1 <= 1'b0;
         flag_light_2 <= 1'b0;
         blocked      <= 1'b0;
         case (state)
            IDLE: begin
               if (up_s || down_s) begin
                  dir_up <= grant_up;
                  rr_up  <= !grant_up;
                  timer  <= '0;
                  state  <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!key_s) begin
                  state <= IDLE;
               end else if (timer == DEB_LAST) begin
                  state        <= FIRE;
                  flag_light_1 <= step_up;
                  flag_light_2 <= step_dn;
                  blocked      <= step_blk;
               end else begin
                  timer <= timer_inc;
               end
            end
            FIRE: begin
               state <= HOLD;
               timer <= '0;
            end
            HOLD: begin
               if (!key_s) begin
                  state <= RELEASE;
                  timer <= '0;
               end else if (timer == REP_LAST) begin
                  state        <= FIRE;
                  flag_light_1 <= step_up;
                  flag_light_2 <= step_dn;
                  blocked      <= step_blk;
               end else begin
                  timer <= timer_inc;
               end
            end
            RELEASE: begin
               if (key_s) begin
                  timer <= '0;
               end else if (timer == DEB_LAST) begin
                  state <= IDLE;
               end else begin
                  timer <= timer_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_step_pulse_arbiter.sv
// Bench for step_pulse_arbiter: countdown behavioural model checked every
// cycle, plus directed scenarios with literal cycle expectations.
module tb_step_pulse_arbiter;

   localparam int D = 4;
   localparam int R = 8;

   logic       FPGA_CLK = 1'b0;
   logic       FPGA_RST_N = 1'b0;
   logic       key_up = 1'b0;
   logic       key_down = 1'b0;
   logic [3:0] count_value = 4'd5;
   logic       flag_light_1;
   logic       flag_light_2;
   logic       blocked;
   logic       busy;

   int tests = 0;
   int fails = 0;

   step_pulse_arbiter #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES(R),
      .CNT_MAX(4'd15)
   ) dut (
      .FPGA_CLK(FPGA_CLK),
      .FPGA_RST_N(FPGA_RST_N),
      .key_up(key_up),
      .key_down(key_down),
      .count_value(count_value),
      .flag_light_1(flag_light_1),
      .flag_light_2(flag_light_2),
      .blocked(blocked),
      .busy(busy)
   );

   always #5 FPGA_CLK = ~FPGA_CLK;

   task automatic chk(string nm, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_i(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 arming, 2 firing, 3 holding, 4 releasing;
   // 'left' counts down the key-stable edges still needed.
   bit [1:0] m_us, m_ds;
   int       m_phase = 0;
   int       m_left = 0;
   bit       m_dir = 1'b1;
   bit       m_rr = 1'b1;
   bit       e_f1, e_f2, e_blk;

   task automatic m_fire();
      m_phase = 2;
      if (m_dir) begin
         e_blk = (count_value == 4'd15);
         e_f1  = !e_blk;
      end else begin
         e_blk = (count_value == 4'd0);
         e_f2  = !e_blk;
      end
   endtask

   always @(posedge FPGA_CLK) begin
      bit us, ds, key;
      e_f1 = 0; e_f2 = 0; e_blk = 0;
      if (!FPGA_RST_N) begin
         m_us = 0; m_ds = 0; m_phase = 0; m_left = 0;
         m_dir = 1; m_rr = 1;
      end else begin
         us = m_us[1];
         ds = m_ds[1];
         m_us = {m_us[0], key_up};
         m_ds = {m_ds[0], key_down};
         key = m_dir ? us : ds;
         case (m_phase)
            0: if (us || ds) begin
               m_dir = (us && ds) ? m_rr : us;
               m_rr = !m_dir;
               m_phase = 1;
               m_left = D;
            end
            1: if (!key) m_phase = 0;
               else begin
                  m_left--;
                  if (m_left == 0) m_fire();
               end
            2: begin m_phase = 3; m_left = R; end
            3: if (!key) begin m_phase = 4; m_left = D; end
               else begin
                  m_left--;
                  if (m_left == 0) m_fire();
               end
            default: if (key) m_left = D;
               else begin
                  m_left--;
                  if (m_left == 0) m_phase = 0;
               end
         endcase
      end
      #1;
      chk("model_f1", flag_light_1, e_f1);
      chk("model_f2", flag_light_2, e_f2);
      chk("model_blk", blocked, e_blk);
      chk("model_busy", busy, m_phase != 0);
   end

   task automatic cyc();
      @(posedge FPGA_CLK);
      #2;
   endtask

   task automatic reset_dut();
      FPGA_RST_N = 0;
      key_up = 0;
      key_down = 0;
      repeat (3) cyc();
      FPGA_RST_N = 1;
   endtask

   initial begin
      int n, p0, p1, bf, nb, nf;

      reset_dut();
      chk("reset_f1", flag_light_1, 1'b0);
      chk("reset_f2", flag_light_2, 1'b0);
      chk("reset_blk", blocked, 1'b0);
      chk("reset_busy", busy, 1'b0);

      // Held up key: pulses at 6 and 15, release at 20
      count_value = 5;
      key_up = 1;
      n = 0; p0 = -1; p1 = -1; bf = -1;
      for (int i = 0; i < 36; i++) begin
         cyc();
         if (i == 1) chk("busy_pre", busy, 1'b0);
         if (i == 2) chk("busy_rise", busy, 1'b1);
         if (flag_light_1) begin
            if (n == 0) p0 = i;
            else if (n == 1) p1 = i;
            n++;
         end
         if (bf < 0 && i > 2 && !busy) bf = i;
         if (i == 20) key_up = 0;
      end
      chk_i("hold_pulses", n, 2);
      chk_i("hold_first", p0, 6);
      chk_i("hold_second", p1, 15);
      chk_i("busy_fall", bf, 27);

      // Short down glitch
      key_down = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (flag_light_2) n++;
         if (i == 1) key_down = 0;
      end
      chk_i("glitch_pulses", n, 0);
      chk("glitch_busy", busy, 1'b0);

      // Round-robin: both together twice
      reset_dut();
      key_up = 1; key_down = 1;
      n = 0; nf = 0; p0 = -1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (flag_light_1) begin n++; p0 = i; end
         if (flag_light_2) nf++;
         if (i == 8) begin key_up = 0; key_down = 0; end
      end
      chk_i("rr1_up", n, 1);
      chk_i("rr1_at", p0, 6);
      chk_i("rr1_down", nf, 0);
      key_up = 1; key_down = 1;
      n = 0; nf = 0; p0 = -1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (flag_light_1) n++;
         if (flag_light_2) begin nf++; p0 = i; end
         if (i == 8) begin key_up = 0; key_down = 0; end
      end
      chk_i("rr2_up", n, 0);
      chk_i("rr2_down", nf, 1);
      chk_i("rr2_at", p0, 6);

      // Blocked at upper bound
      reset_dut();
      count_value = 15;
      key_up = 1;
      nb = 0; nf = 0; p0 = -1;
      for (int i = 0; i < 36; i++) begin
         cyc();
         if (blocked) begin if (nb == 0) p0 = i; nb++; end
         if (flag_light_1) nf++;
         if (i == 20) key_up = 0;
      end
      chk_i("blk_up_cnt", nb, 2);
      chk_i("blk_up_first", p0, 6);
      chk_i("blk_up_f1", nf, 0);

      // Blocked at lower bound
      count_value = 0;
      key_down = 1;
      nb = 0; nf = 0; p0 = -1;
      for (int i = 0; i < 36; i++) begin
         cyc();
         if (blocked) begin if (nb == 0) p0 = i; nb++; end
         if (flag_light_2) nf++;
         if (i == 20) key_down = 0;
      end
      chk_i("blk_dn_cnt", nb, 2);
      chk_i("blk_dn_first", p0, 6);
      chk_i("blk_dn_f2", nf, 0);

      // Reset landing in FIRE, key kept held
      reset_dut();
      count_value = 5;
      key_up = 1;
      p0 = -1;
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (i == 6) begin
            chk("rst_fire_f1", flag_light_1, 1'b1);
            FPGA_RST_N = 0;
         end
         if (i == 7) begin
            chk("rst_after_f1", flag_light_1, 1'b0);
            chk("rst_after_busy", busy, 1'b0);
            FPGA_RST_N = 1;
         end
         if (i > 7 && flag_light_1 && p0 < 0) p0 = i;
      end
      chk_i("rst_repulse", p0, 14);
      key_up = 0;
      repeat (15) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
